// File: rtl/addr_map_rule_pkg.sv
// Address map rule type shared by the external crossbars and demultiplexers.
// A rule selects port idx for addresses in [start_addr, end_addr).
package addr_map_rule_pkg;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_map_rule_t;

endpackage

// File: rtl/ext_periph_demux_pkg.sv
// Shared constants for the external peripheral OBI demultiplexer: default
// rule table, unmapped-access read data and port-select width helper.
package ext_periph_demux_pkg;

  import addr_map_rule_pkg::*;

  localparam logic [31:0] EXT_PERIPHERAL_START_ADDRESS = 32'h2000_0000;
  localparam logic [31:0] EXT_PERIPH_WINDOW            = 32'h0000_1000;
  localparam int          DEFAULT_NPERIPH              = 3;
  localparam logic [31:0] EXT_PERIPH_ERR_RDATA         = 32'hBADC_AB1E;

  // One extra select code beyond the slaves addresses the error responder.
  function automatic int sel_width(input int nperiph);
    return $clog2(nperiph + 1);
  endfunction

  function automatic addr_map_rule_t mk_rule(input int k);
    addr_map_rule_t r;
    r.idx        = 32'(k);
    r.start_addr = EXT_PERIPHERAL_START_ADDRESS + 32'(k) * EXT_PERIPH_WINDOW;
    r.end_addr   = r.start_addr + EXT_PERIPH_WINDOW;
    return r;
  endfunction

  localparam addr_map_rule_t [DEFAULT_NPERIPH-1:0] DEFAULT_ADDR_RULES =
    {mk_rule(2), mk_rule(1), mk_rule(0)};

endpackage

// File: rtl/ext_periph_addr_decode.sv
// Combinational address-rule matcher: lowest matching rule wins, no match
// returns select code NPERIPH with hit low.
module ext_periph_addr_decode
  import addr_map_rule_pkg::*;
  import ext_periph_demux_pkg::*;
#(
  parameter int NPERIPH = 3,
  parameter int ADDR_W  = 32,
  parameter int SEL_W   = sel_width(NPERIPH),
  parameter addr_map_rule_t [NPERIPH-1:0] ADDR_RULES = DEFAULT_ADDR_RULES
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SEL_W-1:0]  sel,
  output logic              hit
);

  always_comb begin
    sel = SEL_W'(NPERIPH);
    hit = 1'b0;
    // Scan downwards so the lowest-indexed overlapping rule is applied last.
    for (int k = NPERIPH - 1; k >= 0; k--) begin
      if ((ADDR_W'(ADDR_RULES[k].start_addr) <= addr) &&
          (addr < ADDR_W'(ADDR_RULES[k].end_addr))) begin
        sel = SEL_W'(ADDR_RULES[k].idx);
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ext_periph_obi_demux.sv
// OBI request demultiplexer for the external peripheral region with in-order
// response tracking and a built-in error responder for unmapped addresses.
// Optional watchdog: define EXT_PERIPH_DEMUX_TIMEOUT_EN.
module ext_periph_obi_demux
  import addr_map_rule_pkg::*;
  import ext_periph_demux_pkg::*;
#(
  parameter int NPERIPH     = 3,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_OUTST   = 4,
  parameter addr_map_rule_t [NPERIPH-1:0] ADDR_RULES = DEFAULT_ADDR_RULES,
  parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(EXT_PERIPH_ERR_RDATA),
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      m_req_i,
  output logic                      m_gnt_o,
  input  logic [ADDR_W-1:0]         m_addr_i,
  input  logic                      m_we_i,
  input  logic [DATA_W/8-1:0]       m_be_i,
  input  logic [DATA_W-1:0]         m_wdata_i,
  output logic                      m_rvalid_o,
  output logic [DATA_W-1:0]         m_rdata_o,
  output logic [NPERIPH-1:0]        s_req_o,
  input  logic [NPERIPH-1:0]        s_gnt_i,
  output logic [ADDR_W-1:0]         s_addr_o,
  output logic                      s_we_o,
  output logic [DATA_W/8-1:0]       s_be_o,
  output logic [DATA_W-1:0]         s_wdata_o,
  input  logic [NPERIPH-1:0]        s_rvalid_i,
  input  logic [NPERIPH*DATA_W-1:0] s_rdata_i,
  output logic                      miss_o,
  output logic                      proto_err_o,
  output logic                      timeout_o
);

  localparam int SEL_W = sel_width(NPERIPH);
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [SEL_W-1:0] ERR_PORT = SEL_W'(NPERIPH);

  logic [SEL_W-1:0]  sel;
  logic              hit;
  logic [SEL_W-1:0]  cur_port;
  logic [CNT_W-1:0]  outst_cnt;
  logic              err_pend;
  logic              proto_err;
  logic              flush;
  logic              flush_rsp;
  logic              issue_ok;
  logic              accept;
  logic              slave_live;
  logic              slave_rvalid;
  logic [DATA_W-1:0] slave_rdata;
  logic              slave_rsp;
  logic              spurious;
  logic              rsp;

  ext_periph_addr_decode #(
    .NPERIPH    (NPERIPH),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .ADDR_RULES (ADDR_RULES)
  ) u_decode (
    .addr (m_addr_i),
    .sel  (sel),
    .hit  (hit)
  );

  assign s_addr_o  = m_addr_i;
  assign s_we_o    = m_we_i;
  assign s_be_o    = m_be_i;
  assign s_wdata_o = m_wdata_i;

  // Request stage: a new target is only addressed once the old one has drained.
  assign issue_ok = ~flush & ((outst_cnt == '0) |
                    ((sel == cur_port) & (outst_cnt < CNT_W'(MAX_OUTST))));

  always_comb begin
    s_req_o = '0;
    m_gnt_o = 1'b0;
    if (issue_ok) begin
      if (hit) begin
        s_req_o[sel] = m_req_i;
        m_gnt_o      = s_gnt_i[sel];
      end else begin
        m_gnt_o = m_req_i;
      end
    end
  end

  assign accept = m_req_i & m_gnt_o;
  assign miss_o = accept & ~hit;

  // Response stage: only the current target may answer while it owes responses.
  assign slave_live = (outst_cnt != '0) & (cur_port != ERR_PORT) & ~flush;

  always_comb begin
    slave_rvalid = 1'b0;
    slave_rdata  = '0;
    spurious     = 1'b0;
    for (int k = 0; k < NPERIPH; k++) begin
      if (cur_port == SEL_W'(k)) begin
        slave_rvalid = s_rvalid_i[k];
        slave_rdata  = s_rdata_i[k*DATA_W +: DATA_W];
      end
      if (s_rvalid_i[k] && !(slave_live && (cur_port == SEL_W'(k))))
        spurious = 1'b1;
    end
  end

  assign flush_rsp = flush & (outst_cnt != '0);
  assign slave_rsp = slave_live & slave_rvalid;
  assign rsp       = slave_rsp | err_pend | flush_rsp;

  assign m_rvalid_o  = rsp;
  assign m_rdata_o   = slave_rsp ? slave_rdata :
                       (err_pend | flush_rsp) ? ERR_RDATA : '0;
  assign proto_err_o = proto_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_cnt <= '0;
      cur_port  <= '0;
      err_pend  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accept)
        cur_port <= sel;
      err_pend <= miss_o;
      if (accept && !rsp)
        outst_cnt <= outst_cnt + CNT_W'(1);
      else if (!accept && rsp)
        outst_cnt <= outst_cnt - CNT_W'(1);
      if (spurious)
        proto_err <= 1'b1;
    end
  end

`ifdef EXT_PERIPH_DEMUX_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // Watchdog: a silent target is retired with one error response per request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_cnt    <= '0;
      flush     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (rsp || (outst_cnt == '0))
        wd_cnt <= '0;
      else
        wd_cnt <= wd_cnt + WD_W'(1);
      if (!flush && (outst_cnt != '0) && !rsp &&
          (wd_cnt == WD_W'(TIMEOUT_CYC - 1))) begin
        flush     <= 1'b1;
        timeout_q <= 1'b1;
      end else if (flush && (outst_cnt == CNT_W'(1))) begin
        flush <= 1'b0;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  // Watchdog compiled out: flag stays low for any legal TIMEOUT_CYC.
  assign flush     = 1'b0;
  assign timeout_o = (TIMEOUT_CYC < 0);
`endif

endmodule

// File: tb/tb_ext_periph_obi_demux.sv
// Self-checking bench for ext_periph_obi_demux: directed vectors plus a
// queue-based transaction model compared every cycle.
module tb_ext_periph_obi_demux;

  localparam int NP = 3;
  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam logic [31:0] ERRD = 32'hBADC_AB1E;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_req = 1'b0;
  logic        m_gnt;
  logic [31:0] m_addr = '0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = '0;
  logic [31:0] m_wdata = '0;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic [2:0]  s_req;
  logic [2:0]  s_gnt = '0;
  logic [31:0] s_addr;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_wdata;
  logic [2:0]  s_rvalid = '0;
  logic [95:0] s_rdata = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
  logic        miss;
  logic        proto_err;
  logic        timeout;

  int nchk = 0;
  int nerr = 0;
  bit model_en = 1'b1;

  ext_periph_obi_demux #(
    .NPERIPH(NP), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(MO), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .miss_o(miss), .proto_err_o(proto_err), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: windows of 4 KiB from BASE map to ports 0..2, anything else to 3.
  function automatic int model_sel(input logic [31:0] a);
    if (a >= BASE && a < BASE + 32'h3000) return int'((a - BASE) >> 12);
    return NP;
  endfunction

  int q_port[$];
  int q_cyc[$];
  int cyc = 0;
  bit m_proto = 1'b0;

  always @(negedge clk) begin : compare
    int sel;
    bit allowed;
    logic       exp_gnt, exp_miss, exp_rv;
    logic [2:0] exp_sreq;
    logic [31:0] exp_rd;
    cyc++;
    if (rst) begin
      q_port.delete();
      q_cyc.delete();
      m_proto = 1'b0;
      chk("rst_gnt", m_gnt, 0);
      chk("rst_rvalid", m_rvalid, 0);
      chk("rst_rdata", m_rdata, 0);
      chk("rst_sreq", s_req, 0);
      chk("rst_miss", miss, 0);
      chk("rst_proto", proto_err, 0);
      chk("rst_timeout", timeout, 0);
    end else if (model_en) begin
      sel = model_sel(m_addr);
      allowed = (q_port.size() == 0) || (sel == q_port[0] && q_port.size() < MO);
      exp_gnt  = allowed && ((sel < NP) ? s_gnt[sel] : m_req);
      exp_sreq = (allowed && sel < NP && m_req) ? 3'(1 << sel) : 3'b000;
      exp_miss = m_req && exp_gnt && (sel == NP);
      exp_rv = 1'b0;
      exp_rd = '0;
      if (q_port.size() > 0) begin
        if (q_port[0] < NP) begin
          exp_rv = s_rvalid[q_port[0]];
          exp_rd = s_rdata[q_port[0]*32 +: 32];
        end else if (q_cyc[0] < cyc) begin
          exp_rv = 1'b1;
          exp_rd = ERRD;
        end
      end
      chk("m_gnt", m_gnt, exp_gnt);
      chk("s_req", s_req, exp_sreq);
      chk("miss", miss, exp_miss);
      chk("m_rvalid", m_rvalid, exp_rv);
      if (exp_rv) chk("m_rdata", m_rdata, exp_rd);
      chk("proto_err", proto_err, m_proto);
      chk("timeout", timeout, 0);
      chk("s_addr", s_addr, m_addr);
      chk("s_wdata", s_wdata, m_wdata);
      for (int k = 0; k < NP; k++)
        if (s_rvalid[k] && !(q_port.size() > 0 && q_port[0] == k)) m_proto = 1'b1;
      if (exp_rv) begin
        void'(q_port.pop_front());
        void'(q_cyc.pop_front());
      end
      if (m_req && exp_gnt) begin
        q_port.push_back(sel);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic drive(input logic req, input logic [31:0] addr, input logic we,
                       input logic [2:0] gnt, input logic [2:0] rv);
    m_req = req;
    m_addr = addr;
    m_we = we;
    m_be = 4'hF;
    m_wdata = addr ^ 32'h5A5A_5A5A;
    s_gnt = gnt;
    s_rvalid = rv;
  endtask

  task automatic settle;
    @(negedge clk);
  endtask

  task automatic advance;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    drive(1'b0, BASE, 1'b0, 3'b000, 3'b000);
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    repeat (2) begin settle(); advance(); end
    rst = 1'b0;
  endtask

  logic [31:0] dec_addr [5];
  logic [2:0]  dec_sreq [5];
  int          n_err_rsp;
  int          first_rsp;

  initial begin
    dec_addr[0] = BASE + 32'h2FFC; dec_sreq[0] = 3'b100;
    dec_addr[1] = BASE + 32'h0FFC; dec_sreq[1] = 3'b001;
    dec_addr[2] = BASE + 32'h1000; dec_sreq[2] = 3'b010;
    dec_addr[3] = BASE - 32'h4;    dec_sreq[3] = 3'b000;
    dec_addr[4] = 32'hFFFF_FFFC;   dec_sreq[4] = 3'b000;

    repeat (3) begin settle(); advance(); end
    rst = 1'b0;
    idle(); settle(); advance();

    // Single read to port 0
    drive(1'b1, BASE + 32'h4, 1'b0, 3'b001, 3'b000);
    settle(); chk("t1_sreq", s_req, 3'b001); chk("t1_gnt", m_gnt, 1); advance();
    drive(1'b0, BASE + 32'h4, 1'b0, 3'b000, 3'b001);
    settle(); chk("t1_rvalid", m_rvalid, 1); chk("t1_rdata", m_rdata, 32'hAAAA_0000); advance();
    idle();
    settle(); chk("t1_cnt", dut.outst_cnt, 0); chk("t1_rvalid_off", m_rvalid, 0); advance();

    // Outstanding limit on port 1
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, BASE + 32'h1000 + 32'(4 * i), 1'b0, 3'b010, 3'b000);
      settle(); chk("t2_gnt", m_gnt, 1); advance();
    end
    drive(1'b1, BASE + 32'h1010, 1'b0, 3'b010, 3'b000);
    settle(); chk("t2_full_gnt", m_gnt, 0); chk("t2_full_sreq", s_req, 0); advance();
    drive(1'b1, BASE + 32'h1010, 1'b0, 3'b010, 3'b010);
    settle(); chk("t2_rsp", m_rvalid, 1); chk("t2_rsp_gnt", m_gnt, 0); advance();
    drive(1'b1, BASE + 32'h1010, 1'b0, 3'b010, 3'b000);
    settle(); chk("t2_fifth_gnt", m_gnt, 1); advance();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, BASE, 1'b0, 3'b000, 3'b010);
      settle(); chk("t2_drain", m_rdata, 32'hBBBB_0001); advance();
    end
    idle(); settle(); chk("t2_cnt", dut.outst_cnt, 0); advance();

    // Target switch waits for drain
    drive(1'b1, BASE + 32'h8, 1'b0, 3'b111, 3'b000);
    settle(); chk("t3_gnt0", m_gnt, 1); advance();
    repeat (2) begin
      drive(1'b1, BASE + 32'h2000, 1'b0, 3'b111, 3'b000);
      settle(); chk("t3_blk_sreq", s_req, 0); chk("t3_blk_gnt", m_gnt, 0); advance();
    end
    drive(1'b1, BASE + 32'h2000, 1'b0, 3'b111, 3'b001);
    settle(); chk("t3_rsp0", m_rvalid, 1); chk("t3_rsp_gnt", m_gnt, 0); advance();
    drive(1'b1, BASE + 32'h2000, 1'b0, 3'b111, 3'b000);
    settle(); chk("t3_sreq2", s_req, 3'b100); chk("t3_gnt2", m_gnt, 1); advance();
    drive(1'b0, BASE, 1'b0, 3'b000, 3'b100);
    settle(); chk("t3_rdata2", m_rdata, 32'hCCCC_0002); advance();

    // Back-to-back misses, last one a write
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, BASE + 32'h3000, (i == 2), 3'b111, 3'b000);
      settle();
      chk("t4_gnt", m_gnt, 1); chk("t4_miss", miss, 1); chk("t4_sreq", s_req, 0);
      if (i == 0) chk("t4_rv0", m_rvalid, 0);
      else begin chk("t4_rv", m_rvalid, 1); chk("t4_rdata", m_rdata, ERRD); end
      advance();
    end
    idle();
    settle(); chk("t4_last_rv", m_rvalid, 1); chk("t4_last_rd", m_rdata, ERRD);
    chk("t4_nomiss", miss, 0); advance();
    settle(); chk("t4_quiet", m_rvalid, 0); advance();

    // Decode boundaries
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, dec_addr[i], 1'b0, 3'b111, 3'b000);
      settle(); chk("dec_sreq", s_req, dec_sreq[i]); chk("dec_gnt", m_gnt, 1);
      chk("dec_miss", miss, (dec_sreq[i] == 3'b000)); advance();
      drive(1'b0, dec_addr[i], 1'b0, 3'b000, dec_sreq[i]);
      settle(); chk("dec_rsp", m_rvalid, 1); advance();
    end

    // Spurious response sets sticky protocol error
    drive(1'b0, BASE, 1'b0, 3'b000, 3'b100);
    settle(); chk("t5_rv", m_rvalid, 0); chk("t5_proto0", proto_err, 0); advance();
    idle();
    repeat (3) begin settle(); chk("t5_proto_hold", proto_err, 1); advance(); end
    do_reset();
    settle(); chk("t5_proto_clr", proto_err, 0); advance();

    // Reset with a request in flight: late response is a protocol error
    drive(1'b1, BASE + 32'h1000, 1'b0, 3'b010, 3'b000);
    settle(); chk("t6_gnt", m_gnt, 1); advance();
    do_reset();
    drive(1'b0, BASE, 1'b0, 3'b000, 3'b010);
    settle(); chk("t6_rv", m_rvalid, 0); advance();
    idle();
    settle(); chk("t6_proto", proto_err, 1); advance();
    do_reset();

`ifdef EXT_PERIPH_DEMUX_TIMEOUT_EN
    // Watchdog retires two reads to a silent slave
    model_en = 1'b0;
    n_err_rsp = 0;
    first_rsp = -1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, BASE + 32'(4 * i), 1'b0, 3'b001, 3'b000);
      settle(); chk("to_gnt", m_gnt, 1); advance();
    end
    idle();
    for (int i = 0; i < 40; i++) begin
      settle();
      if (m_rvalid) begin
        n_err_rsp++;
        if (first_rsp < 0) first_rsp = i;
        chk("to_rdata", m_rdata, ERRD);
      end
      advance();
    end
    chk("to_count", n_err_rsp, 2);
    chk("to_delay", (first_rsp >= 14 && first_rsp <= 17), 1);
    chk("to_flag", timeout, 1);
    drive(1'b1, BASE + 32'h1000, 1'b0, 3'b010, 3'b000);
    settle(); chk("to_next_gnt", m_gnt, 1); advance();
    idle();
`endif

    settle(); advance();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
